// File: rtl/noahgaertner_pkg.sv
// Shared types for the nibble CPU and its upstream loader: command field,
// opcode set, loader state encoding and the image geometry.
package noahgaertner_pkg;

  localparam int IMAGE_WORDS = 16;

  typedef enum logic [1:0] {
    CMD_LOADPROG = 2'd0,
    CMD_LOADDATA = 2'd1,
    CMD_SETRUNPT = 2'd2,
    CMD_RUNPROG  = 2'd3
  } cpu_cmd_e;

  typedef enum logic [3:0] {
    OP_NOP      = 4'd0,
    OP_LDI      = 4'd1,
    OP_ADD      = 4'd2,
    OP_SUB      = 4'd3,
    OP_AND      = 4'd4,
    OP_OR       = 4'd5,
    OP_XOR      = 4'd6,
    OP_LD       = 4'd7,
    OP_ST       = 4'd8,
    OP_JMP      = 4'd9,
    OP_JUMPTOIF = 4'd10,
    OP_HALT     = 4'd15
  } cpu_opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PROG  = 3'd2,
    ST_DATA  = 3'd3,
    ST_SETPT = 3'd4,
    ST_RUN   = 3'd5
`ifdef LOADER_CHECKSUM_EN
    ,
    ST_CHECK = 3'd6
`endif
  } loader_state_e;

endpackage

// File: rtl/noahgaertner_loader_chk.sv
// Running XOR of the accepted image nibbles, compared against the trailing
// check nibble; the error flag is sticky until the next start or reset.
module noahgaertner_loader_chk (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       acc_en,
  input  logic       cmp_en,
  input  logic [3:0] nibble,
  output logic       chk_err
);

  logic [3:0] acc;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      acc     <= 4'd0;
      chk_err <= 1'b0;
    end else begin
      if (acc_en)
        acc <= acc ^ nibble;
      if (cmp_en && (nibble != acc))
        chk_err <= 1'b1;
    end
  end

endmodule

// File: rtl/noahgaertner_loader.sv
// Loader sequencer: clear, 16 program beats, 16 data beats, set run point,
// then N run steps. Define LOADER_CHECKSUM_EN for the CHECK state and chk_err.
// Handshake: a nibble is consumed on a clock edge where in_valid and in_ready
// are both high; in_ready depends only on state, never on in_valid.
module noahgaertner_loader
  import noahgaertner_pkg::*;
#(
  parameter int RUN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       run_pc,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic             jump_req,
  input  logic             in_valid,
  input  logic [3:0]       in_nibble,
  output logic             in_ready,
  output logic             cpu_nrst,
  output logic [1:0]       cpu_mode,
  output logic [3:0]       cpu_nibble,
  output logic             cpu_step,
  output logic             busy,
  output logic             done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic             chk_err
`endif
);

  loader_state_e    state;
  logic             phase;
  logic [3:0]       beat;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] cycles_q;
  logic [3:0]       pc_q;
  logic [3:0]       nib_q;
  logic             jump_q;
  logic             done_q;
  logic             load_hs;
  logic             start_hs;
  logic             last_beat;

  assign start_hs  = (state == ST_IDLE) && start;
  assign load_hs   = ((state == ST_PROG) || (state == ST_DATA)) && !phase && in_valid;
  assign last_beat = (beat == 4'(IMAGE_WORDS - 1));

`ifdef LOADER_CHECKSUM_EN
  logic check_hs;
  assign check_hs = (state == ST_CHECK) && in_valid;

  noahgaertner_loader_chk u_chk (
    .clock   (clock),
    .reset   (reset),
    .clear   (start_hs),
    .acc_en  (load_hs),
    .cmp_en  (check_hs),
    .nibble  (in_nibble),
    .chk_err (chk_err)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      phase    <= 1'b0;
      beat     <= 4'd0;
      run_cnt  <= '0;
      cycles_q <= '0;
      pc_q     <= 4'd0;
      nib_q    <= 4'd0;
      jump_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          phase <= 1'b0;
          if (start_hs) begin
            pc_q     <= run_pc;
            cycles_q <= run_cycles;
            state    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          phase <= !phase;
          if (phase) begin
            beat  <= 4'd0;
            state <= ST_PROG;
          end
        end
        ST_PROG, ST_DATA: begin
          if (!phase) begin
            if (in_valid) begin
              nib_q <= in_nibble;
              phase <= 1'b1;
            end
          end else begin
            phase <= 1'b0;
            beat  <= beat + 4'd1;
            if (last_beat) begin
              if (state == ST_PROG)
                state <= ST_DATA;
              else
`ifdef LOADER_CHECKSUM_EN
                state <= ST_CHECK;
`else
                state <= ST_SETPT;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (check_hs)
            state <= ST_SETPT;
        end
`endif
        ST_SETPT: begin
          phase <= !phase;
          if (phase) begin
            run_cnt <= cycles_q;
            if (cycles_q == '0) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          phase <= !phase;
          if (!phase) begin
            jump_q <= jump_req;
          end else begin
            run_cnt <= run_cnt - RUN_W'(1);
            if (run_cnt == RUN_W'(1)) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          phase <= 1'b0;
        end
      endcase
    end
  end

  // Outputs decode from registered state only, so they hold steady all cycle.
  always_comb begin
    in_ready   = 1'b0;
    cpu_nrst   = 1'b0;
    cpu_mode   = CMD_LOADPROG;
    cpu_nibble = 4'd0;
    case (state)
      ST_PROG: begin
        cpu_nrst   = 1'b1;
        in_ready   = !phase;
        cpu_nibble = nib_q;
      end
      ST_DATA: begin
        cpu_nrst   = 1'b1;
        cpu_mode   = CMD_LOADDATA;
        in_ready   = !phase;
        cpu_nibble = nib_q;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        cpu_nrst = 1'b1;
        cpu_mode = CMD_LOADDATA;
        in_ready = 1'b1;
      end
`endif
      ST_SETPT: begin
        cpu_nrst   = 1'b1;
        cpu_mode   = CMD_SETRUNPT;
        cpu_nibble = pc_q;
      end
      ST_RUN: begin
        cpu_nrst   = 1'b1;
        cpu_mode   = CMD_RUNPROG;
        cpu_nibble = {jump_q, 3'b000};
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign cpu_step = phase;
  assign busy     = (state != ST_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_noahgaertner_loader.sv
// Directed bench for noahgaertner_loader: table of load/run sequences plus a
// hand-written reset-mid-load sequence; works with or without LOADER_CHECKSUM_EN.
module tb_noahgaertner_loader;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] run_pc;
  logic [7:0] run_cycles;
  logic       jump_req;
  logic       in_valid;
  logic [3:0] in_nibble;
  logic       in_ready;
  logic       cpu_nrst;
  logic [1:0] cpu_mode;
  logic [3:0] cpu_nibble;
  logic       cpu_step;
  logic       busy;
  logic       done;
`ifdef LOADER_CHECKSUM_EN
  logic       chk_err;
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  noahgaertner_loader #(.RUN_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .run_pc     (run_pc),
    .run_cycles (run_cycles),
    .jump_req   (jump_req),
    .in_valid   (in_valid),
    .in_nibble  (in_nibble),
    .in_ready   (in_ready),
    .cpu_nrst   (cpu_nrst),
    .cpu_mode   (cpu_mode),
    .cpu_nibble (cpu_nibble),
    .cpu_step   (cpu_step),
    .busy       (busy),
    .done       (done)
`ifdef LOADER_CHECKSUM_EN
    ,
    .chk_err    (chk_err)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  // scoreboard: {nrst, mode, nibble} expected on each cpu_step
  logic [6:0] exp_q[$];

  typedef struct {
    logic [3:0] pc;
    logic [7:0] n;
    logic       jump;
    int         stall_idx;
    int         stall_len;
    logic       busy_start;
    logic       chk_bad;
    int         exp_done;
  } vec_t;

  vec_t vecs[5];
  logic [3:0] img[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},   32'(in_ready),   32'd0);
    check({tag, ".cpu_nrst"},   32'(cpu_nrst),   32'd0);
    check({tag, ".cpu_mode"},   32'(cpu_mode),   32'd0);
    check({tag, ".cpu_nibble"}, 32'(cpu_nibble), 32'd0);
    check({tag, ".cpu_step"},   32'(cpu_step),   32'd0);
    check({tag, ".busy"},       32'(busy),       32'd0);
    check({tag, ".done"},       32'(done),       32'd0);
  endtask

  // driver: one full start-to-done sequence for table entry t
  task automatic run_seq(input int t);
    vec_t v;
    logic [3:0] xsum;
    logic [6:0] exp_w;
    int idx, stall_cnt, cyc;
    logic got_done, prev_step;
    v = vecs[t];
    xsum = 4'd0;
    for (int i = 0; i < 32; i++) begin
      if (t == 0) img[i] = (i < 16) ? 4'(i) : 4'(31 - i);
      else        img[i] = 4'((i * 5 + t * 3) % 16);
      xsum = xsum ^ img[i];
    end
    exp_q.delete();
    exp_q.push_back({1'b0, 2'd0, 4'd0});
    for (int i = 0; i < 32; i++)
      exp_q.push_back({1'b1, (i < 16) ? 2'd0 : 2'd1, img[i]});
    exp_q.push_back({1'b1, 2'd2, v.pc});
    for (int i = 0; i < int'(v.n); i++)
      exp_q.push_back({1'b1, 2'd3, v.jump, 3'b000});

    @(negedge clock);
    start = 1'b1; run_pc = v.pc; run_cycles = v.n; in_valid = 1'b0;
    idx = 0; stall_cnt = 0; cyc = 0; got_done = 1'b0; prev_step = 1'b0;
    while (!got_done && cyc < 300) begin
      @(negedge clock);
      cyc++;
      start      = (v.busy_start && cyc == 40) ? 1'b1 : 1'b0;
      run_pc     = 4'($urandom_range(0, 15));
      run_cycles = 8'($urandom_range(0, 255));
      jump_req   = cpu_step ? ~v.jump : v.jump;
      if (cpu_step && prev_step) check("step_back_to_back", 32'd1, 32'd0);
      if (cpu_step) begin
        if (exp_q.size() == 0) begin
          check("extra_step", 32'd1, 32'd0);
        end else begin
          exp_w = exp_q.pop_front();
          check($sformatf("t%0d.step_fields", t), 32'({cpu_nrst, cpu_mode, cpu_nibble}), 32'(exp_w));
        end
      end
      if (in_ready) check("ready_only_in_setup", 32'({cpu_nrst, cpu_step}), 32'b10);
      if (done) begin
        got_done = 1'b1;
        check($sformatf("t%0d.done_cycle", t), 32'(cyc), 32'(v.exp_done + CHK_EXTRA));
        check("done_busy_low", 32'(busy), 32'd0);
        check("done_no_step", 32'(cpu_step), 32'd0);
        check("steps_left", 32'(exp_q.size()), 32'd0);
        check("nibbles_consumed", 32'(idx), 32'(32 + CHK_EXTRA));
`ifdef LOADER_CHECKSUM_EN
        check("chk_err", 32'(chk_err), 32'(v.chk_bad));
`endif
      end else begin
        check("busy_during_seq", 32'(busy), 32'd1);
      end
      prev_step = cpu_step;
      if (in_ready) begin
        if (idx == v.stall_idx && stall_cnt < v.stall_len) begin
          in_valid = 1'b0;
          in_nibble = 4'($urandom_range(0, 15));
          stall_cnt++;
        end else begin
          in_valid = 1'b1;
          if (idx < 32) in_nibble = img[idx];
          else          in_nibble = v.chk_bad ? (xsum ^ 4'h5) : xsum;
          idx++;
        end
      end else begin
        in_valid  = 1'($urandom_range(0, 1));
        in_nibble = 4'($urandom_range(0, 15));
      end
    end
    if (!got_done) check($sformatf("t%0d.done_timeout", t), 32'd0, 32'd1);
    start = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    // pc, n, jump, stall_idx, stall_len, busy_start, chk_bad, done cycle (no checksum)
    vecs[0] = '{4'd3,  8'd4, 1'b0, -1, 0, 1'b0, 1'b0, 77};
    vecs[1] = '{4'd3,  8'd4, 1'b0, 18, 3, 1'b0, 1'b0, 80};
    vecs[2] = '{4'd5,  8'd0, 1'b0, -1, 0, 1'b0, 1'b0, 69};
    vecs[3] = '{4'd9,  8'd2, 1'b1, -1, 0, 1'b1, 1'b0, 73};
    vecs[4] = '{4'd14, 8'd1, 1'b0,  7, 1, 1'b0, 1'b1, 72};

    reset = 1'b1; start = 1'b0; run_pc = 4'd0; run_cycles = 8'd0;
    jump_req = 1'b0; in_valid = 1'b0; in_nibble = 4'd0;
    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    reset = 1'b0;

    // reset asserted in the SETUP of PROG beat 5
    begin
      int idx, cyc;
      logic fired;
      idx = 0; cyc = 0; fired = 1'b0;
      @(negedge clock);
      start = 1'b1; run_pc = 4'd7; run_cycles = 8'd3;
      while (!fired && cyc < 100) begin
        @(negedge clock);
        cyc++;
        start = 1'b0;
        if (in_ready && idx == 5) begin
          reset = 1'b1; in_valid = 1'b1; in_nibble = 4'd5; fired = 1'b1;
        end else if (in_ready) begin
          in_valid = 1'b1; in_nibble = 4'(idx); idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (!fired) check("reset_mid_load_timeout", 32'd0, 32'd1);
      @(negedge clock);
      check_reset_outputs("mid_load");
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clock);
      check_reset_outputs("after_reset");
    end

    for (int t = 0; t < 5; t++) run_seq(t);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/noahgaertner_loader.md
# noahgaertner_loader

Upstream sequencer for the nibble CPU. Accepts a 32-nibble image (16 program opcodes, then 16 data words) over a valid/ready stream. Drives the CPU's control fields as a timed sequence of beats: clear, LOADPROG ×16, LOADDATA ×16, SETRUNPT, then RUNPROG for a programmed number of steps. Sits between the host/test interface and the CPU input bus; the top level forms the CPU clock from `cpu_step`.

## Interface
- RUN_W, 8, width of the run-step counter.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a load/run sequence; sampled only in IDLE.
- run_pc  in  4  CPU start address for SETRUNPT; latched on accepted start.
- run_cycles  in  RUN_W  number of RUNPROG steps; latched on accepted start.
- jump_req  in  1  condition bit for JUMPTOIF; sampled each RUN setup cycle.
- in_valid  in  1  image nibble valid.
- in_nibble  in  4  image nibble.
- in_ready  out  1  loader accepts a nibble this cycle.
- cpu_nrst  out  1  CPU enable (0 = CPU clears state on its edge).
- cpu_mode  out  2  CPU command: LOADPROG=0, LOADDATA=1, SETRUNPT=2, RUNPROG=3.
- cpu_nibble  out  4  CPU data field.
- cpu_step  out  1  one-cycle strobe; the CPU samples its fields at the end of this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the sequence completes.

## Operation
- States: IDLE, CLEAR, PROG, DATA, SETPT, RUN, (CHECK under macro), back to IDLE.
- Every beat has two phases, SETUP (step=0) then STEP (step=1). Fields are valid throughout the STEP cycle.
- IDLE: nrst=0, step=0. start=1 latches run_pc and run_cycles, then goes to CLEAR.
- CLEAR: one beat with nrst=0 and mode=0, which zeroes the CPU's pc, register and memories.
- PROG/DATA:
  - nrst=1; mode=0 or 1.
  - in_ready=1 only in the SETUP phase.
  - On handshake, the nibble goes to a hold register that drives cpu_nibble; the next cycle is STEP.
  - in_valid=0 stalls in SETUP indefinitely with no step.
  - A 4-bit beat counter advances after each STEP. On wrap 15→0, PROG moves to DATA and DATA moves to SETPT. The CPU pc also wraps, so both files are fully written.
- SETPT: one beat, mode=2, cpu_nibble=run_pc.
- RUN:
  - mode=3; cpu_nibble={jump_req,3'b000}, with jump_req captured in SETUP.
  - The step counter decrements after each STEP; reaching 0 goes to IDLE with done.
  - If run_cycles=0, the loader skips RUN: SETPT's STEP goes directly to done.
- in_ready=0 in every state other than PROG/DATA SETUP (and CHECK).
- Inputs offered outside a ready window are ignored and never consumed.
- start while busy is ignored.
- reset at any cycle returns the loader to IDLE. Reset values:
  - in_ready=0, cpu_nrst=0, cpu_mode=0, cpu_nibble=0, cpu_step=0, busy=0, done=0.
  - Counters and hold register cleared.

## Timing
- Counting the start-sampling cycle as 0, with no input stalls:
  - CLEAR occupies cycles 1–2.
  - Loads occupy cycles 3–66.
  - SETPT occupies cycles 67–68.
  - RUN occupies cycles 69 to 68+2N.
  - done pulses in cycle 69+2N, and busy falls in the same cycle.
- Each cycle with in_valid=0 in PROG/DATA SETUP adds exactly one cycle.
- cpu_step is never high for two consecutive cycles.
- done is registered; it is never asserted while cpu_step=1.

## Configuration
- Macro LOADER_CHECKSUM_EN adds a CHECK state and a `chk_err` output (out, 1 bit).
- With the macro defined:
  - The loader XORs all 32 accepted nibbles.
  - After DATA, CHECK accepts one extra nibble with in_ready=1 and no step.
  - chk_err is set if that nibble does not equal the XOR. It stays set until the next accepted start or reset.
  - The sequence continues to SETPT regardless of chk_err.
  - Done timing becomes 70+2N.
- Without the macro: no CHECK state, no chk_err port.

## Structure
- Package noahgaertner_pkg holds:
  - the CPU command enum (LOADPROG/LOADDATA/SETRUNPT/RUNPROG, 2 bits);
  - the opcode enum shared with the CPU;
  - the loader state enum;
  - the constant IMAGE_WORDS=16.
- One sub-module: noahgaertner_loader_chk (XOR accumulator and comparator), instantiated only under LOADER_CHECKSUM_EN.

## Test plan
- Reset mid-load: reset asserted in PROG beat 5 → the next cycle shows all outputs at reset values; a subsequent start performs a full CLEAR first.
- Nominal: image 0..15 then 15..0, run_pc=3, run_cycles=4, no stalls → 32 steps with modes 0 then 1 and nibbles in order, SETPT nibble=3, 4 RUN steps, done at cycle 77.
- Stall: in_valid low for 3 cycles before DATA beat 2 → in_ready stays high and no step occurs; done at cycle 80 with N=4.
- run_cycles=0 → no RUNPROG steps; done at cycle 69.
- jump_req=1 during RUN → cpu_nibble=4'b1000 on each RUN step; start pulsed while busy changes nothing.
- With LOADER_CHECKSUM_EN: correct XOR nibble → chk_err=0 and done at 70+2N; wrong nibble → chk_err=1 and the run still completes.
